controle_rodada: RTL and testbench

Round controller for the chess-square training game. It sits directly downstream of the move generator.
- Each round it pulses novaJogada to the generator and latches the square the generator produces (coluna/linha, 1..8).
- It shows that target square, then waits for the player to enter and confirm a square.
- It scores each round as a hit or a miss (including timeout), and ends the game after NUM_RODADAS rounds.

---
 rtl/jogo_defs.sv | 22 ++
 rtl/temporizador_rodada.sv | 28 ++
 rtl/controle_rodada.sv | 141 ++++++++++++++
 tb/tb_controle_rodada.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/jogo_defs.sv
// Shared definitions for the chess-square training game: FSM states and coordinate limits.
package jogo_defs;

    localparam int unsigned LARGURA_COORD = 4;
    localparam logic [LARGURA_COORD-1:0] COORD_MIN = 4'd1;
    localparam logic [LARGURA_COORD-1:0] COORD_MAX = 4'd8;

    typedef enum logic [2:0] {
        StInicial = 3'd0,
        StSorteia = 3'd1,
        StCaptura = 3'd2,
        StEspera  = 3'd3,
        StAvalia  = 3'd4,
        StProxima = 3'd5,
        StFim     = 3'd6
    } estado_t;

    function automatic logic coord_valida(input logic [LARGURA_COORD-1:0] c);
        return (c >= COORD_MIN) && (c <= COORD_MAX);
    endfunction

endpackage

// File: rtl/temporizador_rodada.sv
// Clearable up-counter for the player response window; fim flags the terminal count.
module temporizador_rodada #(
    parameter int unsigned TIMEOUT_CICLOS = 5000
) (
    input  logic clock,
    input  logic reset,
    input  logic zera,
    input  logic conta,
    output logic fim
);

    localparam int unsigned LARGURA = $clog2(TIMEOUT_CICLOS);
    localparam logic [LARGURA-1:0] TERMINAL = LARGURA'(TIMEOUT_CICLOS - 1);

    logic [LARGURA-1:0] contagem_q;

    // Holds at the terminal count so the value never wraps while waiting.
    always_ff @(posedge clock) begin
        if (reset || zera) begin
            contagem_q <= '0;
        end else if (conta && !fim) begin
            contagem_q <= contagem_q + LARGURA'(1);
        end
    end

    assign fim = (contagem_q == TERMINAL);

endmodule

// File: rtl/controle_rodada.sv
// Round controller: requests a target square, waits for the player's answer, scores the round
// and ends the game after NUM_RODADAS rounds.
module controle_rodada
    import jogo_defs::*;
#(
    parameter int unsigned NUM_RODADAS    = 8,
    parameter int unsigned TIMEOUT_CICLOS = 5000,
    parameter int unsigned LARGURA_PONTOS = 4
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      iniciar,
    output logic                      novaJogada,
    input  logic [3:0]                coluna_alvo,
    input  logic [3:0]                linha_alvo,
    input  logic [3:0]                coluna_jogador,
    input  logic [3:0]                linha_jogador,
    input  logic                      confirma,
    output logic [3:0]                coluna_mostra,
    output logic [3:0]                linha_mostra,
    output logic                      acerto,
    output logic                      erro,
    output logic [LARGURA_PONTOS-1:0] pontos,
    output logic [3:0]                rodada,
    output logic                      pronto,
    output logic [2:0]                estado
);

    localparam logic [3:0] ULTIMA_RODADA = 4'(NUM_RODADAS - 1);

    estado_t                   estado_q, estado_d;
    logic [3:0]                coluna_mostra_q, linha_mostra_q;
    logic [3:0]                coluna_jog_q, linha_jog_q;
    logic                      timeout_q;
    logic [LARGURA_PONTOS-1:0] pontos_q;
    logic [3:0]                rodada_q;

    logic timer_zera, timer_conta, timer_fim;
    logic alvo_valido, acertou;

    temporizador_rodada #(
        .TIMEOUT_CICLOS(TIMEOUT_CICLOS)
    ) u_temporizador (
        .clock(clock),
        .reset(reset),
        .zera (timer_zera),
        .conta(timer_conta),
        .fim  (timer_fim)
    );

    assign alvo_valido = coord_valida(coluna_alvo) && coord_valida(linha_alvo);
    assign acertou     = !timeout_q
                         && (coluna_jog_q == coluna_mostra_q) && (linha_jog_q == linha_mostra_q)
                         && coord_valida(coluna_jog_q) && coord_valida(linha_jog_q);

    always_comb begin
        estado_d    = estado_q;
        novaJogada  = 1'b0;
        timer_zera  = 1'b0;
        timer_conta = 1'b0;
        case (estado_q)
            StInicial: if (iniciar) estado_d = StSorteia;
            StSorteia: begin
                novaJogada = 1'b1;
                estado_d   = StCaptura;
            end
            StCaptura: begin
                if (alvo_valido) begin
                    estado_d   = StEspera;
                    timer_zera = 1'b1;
                end else begin
                    estado_d = StSorteia;
                end
            end
            StEspera: begin
                timer_conta = 1'b1;
                if (confirma || timer_fim) estado_d = StAvalia;
            end
            StAvalia:  estado_d = StProxima;
            StProxima: estado_d = (rodada_q == ULTIMA_RODADA) ? StFim : StSorteia;
            StFim:     if (iniciar) estado_d = StSorteia;
            default:   estado_d = StInicial;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            estado_q        <= StInicial;
            coluna_mostra_q <= '0;
            linha_mostra_q  <= '0;
            coluna_jog_q    <= '0;
            linha_jog_q     <= '0;
            timeout_q       <= 1'b0;
            pontos_q        <= '0;
            rodada_q        <= '0;
        end else begin
            estado_q <= estado_d;
            case (estado_q)
                StInicial, StFim: begin
                    if (iniciar) begin
                        pontos_q <= '0;
                        rodada_q <= '0;
                    end
                end
                StCaptura: begin
                    if (alvo_valido) begin
                        coluna_mostra_q <= coluna_alvo;
                        linha_mostra_q  <= linha_alvo;
                    end
                end
                StEspera: begin
                    // A confirm on the terminal cycle still counts as an answer.
                    if (confirma) begin
                        coluna_jog_q <= coluna_jogador;
                        linha_jog_q  <= linha_jogador;
                        timeout_q    <= 1'b0;
                    end else if (timer_fim) begin
                        timeout_q <= 1'b1;
                    end
                end
                StAvalia: begin
                    if (acertou && (pontos_q != '1)) pontos_q <= pontos_q + LARGURA_PONTOS'(1);
                end
                StProxima: begin
                    if (rodada_q != ULTIMA_RODADA) rodada_q <= rodada_q + 4'd1;
                end
                default: ;
            endcase
        end
    end

    assign coluna_mostra = coluna_mostra_q;
    assign linha_mostra  = linha_mostra_q;
    assign acerto        = (estado_q == StAvalia) && acertou;
    assign erro          = (estado_q == StAvalia) && !acertou;
    assign pontos        = pontos_q;
    assign rodada        = rodada_q;
    assign pronto        = (estado_q == StFim);
    assign estado        = estado_q;

endmodule

// File: tb/tb_controle_rodada.sv
// Self-checking bench for controle_rodada: directed and random rounds against a round-level model.
module tb_controle_rodada;

    localparam int unsigned NR = 8;
    localparam int unsigned TO = 10;
    localparam int unsigned LP = 3;
    localparam int PONTOS_MAX  = (1 << LP) - 1;

    logic          clock = 1'b0;
    logic          reset, iniciar, confirma;
    logic          novaJogada, acerto, erro, pronto;
    logic [3:0]    coluna_alvo, linha_alvo, coluna_jogador, linha_jogador;
    logic [3:0]    coluna_mostra, linha_mostra, rodada;
    logic [LP-1:0] pontos;
    logic [2:0]    estado;

    int checks = 0;
    int errors = 0;
    int pontos_m, rodada_m, mostra_c_m, mostra_l_m;

    controle_rodada #(
        .NUM_RODADAS   (NR),
        .TIMEOUT_CICLOS(TO),
        .LARGURA_PONTOS(LP)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .iniciar       (iniciar),
        .novaJogada    (novaJogada),
        .coluna_alvo   (coluna_alvo),
        .linha_alvo    (linha_alvo),
        .coluna_jogador(coluna_jogador),
        .linha_jogador (linha_jogador),
        .confirma      (confirma),
        .coluna_mostra (coluna_mostra),
        .linha_mostra  (linha_mostra),
        .acerto        (acerto),
        .erro          (erro),
        .pontos        (pontos),
        .rodada        (rodada),
        .pronto        (pronto),
        .estado        (estado)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no completion, required completion within 20000 cycles");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
        end
    endtask

    // A round scores only when answered in time with an on-board square equal to the target.
    function automatic bit modelo_acerto(input int ac, input int al, input int jc, input int jl,
                                         input int atraso);
        bit no_tabuleiro = (jc >= 1) && (jc <= 8) && (jl >= 1) && (jl <= 8);
        return (atraso >= 0) && (atraso < int'(TO)) && (jc == ac) && (jl == al) && no_tabuleiro;
    endfunction

    // Generator returns an off-board square: a fresh request must follow, display untouched.
    task automatic redraw(input int ac, input int al);
        chk("redraw_nova", novaJogada, 1);
        coluna_alvo = 4'(ac);
        linha_alvo  = 4'(al);
        step();
        chk("redraw_captura", estado, 2);
        step();
        chk("redraw_sorteia", estado, 1);
        chk("redraw_nova_again", novaJogada, 1);
        chk("redraw_mostra_c", coluna_mostra, mostra_c_m);
        chk("redraw_mostra_l", linha_mostra, mostra_l_m);
    endtask

    // One round starting in the request cycle; atraso < 0 means the player never confirms.
    task automatic jogar(input int ac, input int al, input int jc, input int jl,
                         input int atraso, input bit iniciar_em_espera);
        bit hit;
        chk("round_nova", novaJogada, 1);
        chk("round_sorteia", estado, 1);
        coluna_alvo    = 4'(ac);
        linha_alvo     = 4'(al);
        coluna_jogador = 4'(jc);
        linha_jogador  = 4'(jl);
        step();
        chk("round_captura", estado, 2);
        chk("round_nova_once", novaJogada, 0);
        step();
        chk("round_espera", estado, 3);
        mostra_c_m = ac;
        mostra_l_m = al;
        chk("round_mostra_c", coluna_mostra, mostra_c_m);
        chk("round_mostra_l", linha_mostra, mostra_l_m);
        if (atraso >= 0 && atraso < int'(TO)) begin
            for (int i = 0; i < atraso; i++) begin
                if (i == 0 && iniciar_em_espera) iniciar = 1'b1;
                step();
                iniciar = 1'b0;
                chk("round_wait", estado, 3);
            end
            confirma = 1'b1;
            step();
            confirma = 1'b0;
        end else begin
            for (int i = 1; i < int'(TO); i++) begin
                step();
                chk("timeout_wait", estado, 3);
                chk("timeout_no_erro", erro, 0);
            end
            step();
        end
        hit = modelo_acerto(ac, al, jc, jl, atraso);
        chk("round_avalia", estado, 4);
        chk("round_acerto", acerto, 32'(hit));
        chk("round_erro", erro, 32'(!hit));
        if (hit && pontos_m < PONTOS_MAX) pontos_m++;
        step();
        chk("round_proxima", estado, 5);
        chk("round_no_pulse", acerto | erro, 0);
        chk("round_pontos", pontos, pontos_m);
        step();
        if (rodada_m == int'(NR) - 1) begin
            chk("end_fim", estado, 6);
            chk("end_pronto", pronto, 1);
        end else begin
            rodada_m++;
            chk("next_sorteia", estado, 1);
        end
        chk("round_rodada", rodada, rodada_m);
    endtask

    task automatic jogar_aleatoria(input bit sempre_acerta);
        int ac, al, jc, jl, atraso, modo;
        ac     = int'($urandom_range(1, 8));
        al     = int'($urandom_range(1, 8));
        jc     = ac;
        jl     = al;
        atraso = int'($urandom_range(0, TO - 1));
        modo   = sempre_acerta ? 0 : int'($urandom_range(0, 3));
        if (modo == 2) begin
            jc = int'($urandom_range(0, 9));
            jl = int'($urandom_range(0, 9));
        end else if (modo == 3) begin
            atraso = -1;
        end
        jogar(ac, al, jc, jl, atraso, 1'b0);
    endtask

    task automatic comecar();
        iniciar = 1'b1;
        step();
        iniciar = 1'b0;
        pontos_m = 0;
        rodada_m = 0;
        chk("start_sorteia", estado, 1);
        chk("start_nova", novaJogada, 1);
        chk("start_pontos", pontos, 0);
        chk("start_rodada", rodada, 0);
        chk("start_pronto", pronto, 0);
    endtask

    initial begin
        reset = 1'b1; iniciar = 1'b0; confirma = 1'b0;
        coluna_alvo = '0; linha_alvo = '0; coluna_jogador = '0; linha_jogador = '0;
        mostra_c_m = 0; mostra_l_m = 0;
        step();
        step();
        chk("reset_estado", estado, 0);
        chk("reset_nova", novaJogada, 0);
        chk("reset_pontos", pontos, 0);
        chk("reset_rodada", rodada, 0);
        chk("reset_pronto", pronto, 0);
        chk("reset_mostra", {coluna_mostra, linha_mostra}, 0);
        chk("reset_pulses", acerto | erro, 0);
        reset = 1'b0;
        confirma = 1'b1;
        step();
        confirma = 1'b0;
        chk("idle_confirma_ignored", estado, 0);

        // Game 1: directed rounds, then random ones up to FIM.
        comecar();
        jogar(3, 5, 3, 5, 2, 1'b0);
        jogar(8, 1, 1, 8, 0, 1'b0);
        redraw(0, 4);
        redraw(9, 2);
        jogar(2, 2, 0, 1, 3, 1'b0);
        jogar(5, 6, 5, 6, -1, 1'b0);
        jogar(7, 2, 7, 2, TO - 1, 1'b1);
        for (int r = 5; r < int'(NR); r++) jogar_aleatoria(1'b0);

        for (int i = 0; i < 3; i++) begin
            confirma = 1'b1;
            step();
            confirma = 1'b0;
            chk("fim_hold_estado", estado, 6);
            chk("fim_hold_pontos", pontos, pontos_m);
            chk("fim_hold_rodada", rodada, NR - 1);
            chk("fim_hold_mostra", {coluna_mostra, linha_mostra}, {mostra_c_m[3:0], mostra_l_m[3:0]});
        end

        // Game 2: every round a hit, score saturates.
        comecar();
        for (int r = 0; r < int'(NR); r++) jogar_aleatoria(1'b1);
        chk("sat_pontos", pontos, PONTOS_MAX);
        chk("sat_pronto", pronto, 1);

        // Game 3: reset in the middle of a round.
        comecar();
        jogar_aleatoria(1'b0);
        jogar_aleatoria(1'b0);
        coluna_alvo = 4'd4;
        linha_alvo  = 4'd4;
        step();
        step();
        chk("midreset_espera", estado, 3);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("midreset_estado", estado, 0);
        chk("midreset_outputs", {novaJogada, acerto, erro, pronto, pontos, rodada}, 0);
        chk("midreset_mostra", {coluna_mostra, linha_mostra}, 0);
        coluna_jogador = 4'd4;
        linha_jogador  = 4'd4;
        confirma = 1'b1;
        step();
        confirma = 1'b0;
        chk("midreset_confirma_ignored", estado, 0);
        chk("midreset_no_pulse", acerto | erro, 0);
        step();
        chk("midreset_idle", {estado, pontos}, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
